// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one add/subtract unit between NUM_REQ requesters.
// A requester may lock the unit to chain carries across back-to-back operations.
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic [NUM_REQ-1:0]         req_sub,
  input  logic [NUM_REQ-1:0]         req_chain,
  input  logic [NUM_REQ*WIDTH-1:0]   op_a,
  input  logic [NUM_REQ*WIDTH-1:0]   op_b,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_carry,
  output logic                       rsp_ovf,
  output logic                       locked
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state;
  logic [IW-1:0]   last_gnt;
  logic [IW-1:0]   owner;
  logic            carry_reg;

  logic [NUM_REQ-1:0] rr_gnt;
  logic [IW-1:0]      rr_idx;
  logic               rr_found;
  logic [IW:0]        cand;
  logic [IW-1:0]      gnt_idx;
  logic               any_gnt;

  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_sub;
  logic               sel_chain;
  logic [WIDTH-1:0]   b_eff;
  logic               cin;
  logic [WIDTH:0]     sum;
  logic               ovf;

  // Search upward from last_gnt+1; cand is one bit wider so the wrap is a single subtract.
  always_comb begin
    rr_gnt   = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_gnt} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!rr_found && req[cand[IW-1:0]]) begin
        rr_found              = 1'b1;
        rr_gnt[cand[IW-1:0]]  = 1'b1;
        rr_idx                = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    if (state == LOCKED) begin
      if (req[owner]) begin
        gnt[owner] = 1'b1;
        gnt_idx    = owner;
      end
    end else begin
      gnt     = rr_gnt;
      gnt_idx = rr_idx;
    end
  end

  assign any_gnt = |gnt;

  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_sub   = 1'b0;
    sel_chain = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a     = op_a[i*WIDTH +: WIDTH];
        sel_b     = op_b[i*WIDTH +: WIDTH];
        sel_sub   = req_sub[i];
        sel_chain = req_chain[i];
      end
    end
  end

  // Subtract is a + ~b + 1; a chained op replaces that +1 with the stored carry.
  assign b_eff = sel_sub ? ~sel_b : sel_b;
  assign cin   = sel_chain ? carry_reg : sel_sub;
  assign sum   = {1'b0, sel_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  assign ovf   = (sel_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != sel_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= IW'(NUM_REQ-1);
      owner     <= '0;
      carry_reg <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_ovf   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      rsp_valid <= gnt;
      if (any_gnt) begin
        rsp_data  <= sum[WIDTH-1:0];
        rsp_carry <= sum[WIDTH];
        rsp_ovf   <= ovf;
        carry_reg <= sum[WIDTH];
      end
      case (state)
        IDLE: begin
          if (any_gnt) begin
            last_gnt <= gnt_idx;
            if (req_lock[gnt_idx]) begin
              state  <= LOCKED;
              owner  <= gnt_idx;
              locked <= 1'b1;
            end
          end
        end
        LOCKED: begin
          // Owner either released its request or issued its final (unlocked) beat.
          if (!req[owner] || !req_lock[owner]) begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one WIDTH-bit add/subtract unit between NUM_REQ requesters in the MIPS core: address generation, branch target, ALU spill and the HI/LO multi-word path.
- Round-robin grant.
- Optional lock lets one requester issue back-to-back chained operations for wide arithmetic; the carry of its previous operation feeds its next one.
- Result is registered and returned one cycle after grant.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request; held until granted.
- req_lock  input  NUM_REQ  per-requester lock request, sampled with req.
- req_sub  input  NUM_REQ  1 = subtract (a - b), 0 = add.
- req_chain  input  NUM_REQ  1 = use the stored carry as carry-in.
- op_a  input  NUM_REQ*WIDTH  packed operand A; slice i belongs to requester i.
- op_b  input  NUM_REQ*WIDTH  packed operand B.
- gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as req.
- rsp_valid  output  NUM_REQ  one-hot, one-cycle result strobe.
- rsp_data  output  WIDTH  registered result.
- rsp_carry  output  1  registered carry-out (add) or not-borrow (sub).
- rsp_ovf  output  1  registered signed overflow.
- locked  output  1  high while in LOCKED state.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. rst_n low forces:
  - state = IDLE, last_gnt pointer = NUM_REQ-1 (so requester 0 has first priority), carry_reg = 0, owner = 0;
  - rsp_valid = 0, rsp_data = 0, rsp_carry = 0, rsp_ovf = 0, locked = 0.
- State IDLE (arbitration):
  - gnt = first asserted req searching from last_gnt+1 upward, wrapping modulo NUM_REQ.
  - No req: gnt = 0 and nothing changes.
  - Each grant updates last_gnt.
- State LOCKED:
  - Only owner can be granted; all other requests get gnt = 0 and keep waiting.
  - last_gnt is not updated.
- Transitions:
  - IDLE->LOCKED: granted requester has req_lock = 1; owner is set to that requester.
  - LOCKED->IDLE: owner granted with req_lock = 0 (that operation still executes), or owner req low in any LOCKED cycle.
  - On return to IDLE, arbitration resumes from last_gnt+1, so the owner has the lowest priority.
- Datapath (cycle t = grant cycle), with i the granted requester:
  - cin = req_chain[i] ? carry_reg : req_sub[i].
  - B' = req_sub[i] ? ~op_b_i : op_b_i.
  - {c, s} = op_a_i + B' + cin, computed at WIDTH+1 bits.
  - ovf = (a[MSB] == B'[MSB]) && (s[MSB] != a[MSB]).
- Registered response (edge ending cycle t):
  - rsp_data = s, rsp_carry = c, rsp_ovf = ovf, carry_reg = c.
  - rsp_valid = one-hot(i) during cycle t+1; otherwise rsp_valid = 0.
  - rsp_data/rsp_carry/rsp_ovf hold their last values when no grant occurs.
- Latency and throughput: latency 1 cycle; one operation per cycle; no backpressure on responses.
- carry_reg is shared: a chained operation is only meaningful inside a lock or immediately after the same requester's previous grant. No per-requester carry is kept.
- Reset mid-lock: lock is dropped immediately and any in-flight response is discarded (rsp_valid = 0).
- Simultaneous events: a new grant and a response strobe in the same cycle are independent. A requester may re-request in the cycle its rsp_valid is high.

Test Plan:
- Single op: req[2] = 1, op_a = 5, op_b = 7, add -> gnt = 0100 same cycle; next cycle rsp_valid = 0100, rsp_data = 12, rsp_carry = 0, rsp_ovf = 0.
- Round robin: all four req held high from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001; each rsp_valid follows one cycle later.
- 64-bit chained add, lock held by req[1]:
  - Beat 1: lock = 1, a = FFFFFFFF, b = 00000001.
  - Beat 2: chain = 1, lock = 0, a = 0, b = 0.
  - Required: rsp_data 00000000 then 00000001; rsp_carry 1 then 0.
  - req[3] asserted meanwhile is not granted until the cycle after beat 2.
- Subtract overflow: a = 80000000, b = 00000001, sub -> rsp_data = 7FFFFFFF, rsp_ovf = 1, rsp_carry = 1. Then a = 3, b = 5, sub -> FFFFFFFE, rsp_carry = 0, rsp_ovf = 0.
- Lock abandon: owner 0 takes lock, then drops req while req[2] is high -> locked falls, gnt = 0100 in the same cycle.
- Reset mid-lock: assert rst_n low asynchronously between edges during LOCKED -> locked, rsp_valid and gnt-pointer state clear immediately. After release, with all req high, the first grant is requester 0.
